arcade_input_mapper: RTL

- Parametrised successor to the per-core keyboard/joystick glue in each arcade top level.
- Decodes PS/2 key events and merges PLAYERS joystick words into per-player direction, button and start lines, plus a coin line.
- Applies a rotation remap that covers all four screen orientations.
- Generates a timed coin pulse with a guaranteed release gap, feeding the game core's active-high-converted control inputs.

---
 rtl/arcade_input_pkg.sv | 82 ++++++++
 rtl/arcade_input_mapper_coin.sv | 101 ++++++++++
 rtl/arcade_input_mapper.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg
//   Shared constants and types for the arcade input mapper:
//   - PS/2 scan codes (9 bits, bit 8 = E0 extended prefix)
//   - joystick word bit positions
//   - indices into the keyboard key-state vector
//   - rotation mode and coin FSM state enums
//   - rotate_dir(): orientation remap of a {U,D,L,R} direction nibble
`timescale 1ns/1ps
package arcade_input_pkg;

  // Player 1 keys
  localparam logic [8:0] SC_P1_UP    = 9'h175;
  localparam logic [8:0] SC_P1_DOWN  = 9'h172;
  localparam logic [8:0] SC_P1_LEFT  = 9'h16B;
  localparam logic [8:0] SC_P1_RIGHT = 9'h174;
  localparam logic [8:0] SC_P1_B0A   = 9'h029;
  localparam logic [8:0] SC_P1_B0B   = 9'h014;
  localparam logic [8:0] SC_P1_B1    = 9'h011;
  // Player 2 keys
  localparam logic [8:0] SC_P2_UP    = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT  = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT = 9'h034;
  localparam logic [8:0] SC_P2_B0    = 9'h01C;
  // System keys
  localparam logic [8:0] SC_START0   = 9'h005;
  localparam logic [8:0] SC_START1   = 9'h006;
  localparam logic [8:0] SC_COIN     = 9'h02E;

  // Joystick word bit positions; direction nibbles use the same order
  localparam int JOY_R    = 0;
  localparam int JOY_L    = 1;
  localparam int JOY_D    = 2;
  localparam int JOY_U    = 3;
  localparam int JOY_BTN0 = 4;

  // Key-state vector layout. Both button-0 keys of player 1 keep their own
  // bit so releasing one while the other is held leaves the button pressed.
  localparam int K_P1_U   = 0;
  localparam int K_P1_D   = 1;
  localparam int K_P1_L   = 2;
  localparam int K_P1_R   = 3;
  localparam int K_P1_B0A = 4;
  localparam int K_P1_B0B = 5;
  localparam int K_P1_B1  = 6;
  localparam int K_P2_U   = 7;
  localparam int K_P2_D   = 8;
  localparam int K_P2_L   = 9;
  localparam int K_P2_R   = 10;
  localparam int K_P2_B0  = 11;
  localparam int K_START0 = 12;
  localparam int K_START1 = 13;
  localparam int K_COIN   = 14;
  localparam int KEY_N    = 15;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_180  = 2'd2,
    ROT_CCW  = 2'd3
  } rot_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  // Input and result are both indexed by JOY_U/D/L/R.
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    logic [3:0] o;
    o = d;
    case (r)
      ROT_CW:  o = {d[JOY_L], d[JOY_R], d[JOY_D], d[JOY_U]};
      ROT_180: o = {d[JOY_D], d[JOY_U], d[JOY_R], d[JOY_L]};
      ROT_CCW: o = {d[JOY_R], d[JOY_L], d[JOY_U], d[JOY_D]};
      default: o = d;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin.sv
// arcade_coin_pulser
//   Turns rising edges of a coin request into fixed-length coin pulses with
//   a guaranteed low gap of the same length. One request arriving during a
//   pulse or gap is remembered and served after the gap; further ones drop.
// Ports:
//   clk_sys  - system clock
//   I_RESETn - asynchronous active-low reset
//   trigger  - coin request level (edge detected here)
//   coin     - registered coin pulse, active high
`timescale 1ns/1ps
module arcade_coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 2457600,
  parameter int CNT_W      = 22
) (
  input  logic clk_sys,
  input  logic I_RESETn,
  input  logic trigger,
  output logic coin
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(COIN_PULSE - 1);

  coin_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             coin_q, coin_d;
  logic             trig_prev_q;
  logic             edge_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    coin_d  = coin_q;
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          state_d = PULSE;
          cnt_d   = RELOAD;
          coin_d  = 1'b1;
        end
      end
      PULSE: begin
        if (edge_q) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          coin_d  = 1'b0;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_q || edge_q) begin
            state_d = PULSE;
            cnt_d   = RELOAD;
            coin_d  = 1'b1;
            // A queued request is consumed; a fresh edge on this same cycle
            // becomes the new queued one.
            pend_d  = pend_q & edge_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (edge_q) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        coin_d  = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      coin_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      coin_q      <= coin_d;
      trig_prev_q <= trigger;
      edge_q      <= trigger & ~trig_prev_q;
    end
  end

  assign coin = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Merges PS/2 keyboard events and per-player joystick words into registered
//   per-player direction/button/start lines, applies screen-rotation remap and
//   drives a timed coin pulse.
//   Optional build macro INPUT_SOCD_EN: after rotation, opposing directions
//   pressed together (up+down, left+right) are both cleared.
// Ports:
//   clk_sys   - system clock
//   I_RESETn  - asynchronous active-low reset
//   ps2_key   - [10] event toggle, [9] pressed, [8:0] scan code
//   joystick  - 16-bit word per player
//   merge     - OR all joysticks into every player
//   rotate    - 0 none, 1 cw90, 2 180, 3 ccw90
//   auto_coin - any start press also requests a coin
//   dir       - per player {up,down,left,right}
//   btn       - per player BUTTONS fire buttons
//   start     - per player start
//   coin      - coin pulse
`timescale 1ns/1ps
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 2,
  parameter int COIN_PULSE = 2457600,
  parameter int CNT_W      = 22
) (
  input  logic                       clk_sys,
  input  logic                       I_RESETn,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joystick,
  input  logic                       merge,
  input  logic [1:0]                 rotate,
  input  logic                       auto_coin,
  output logic [4*PLAYERS-1:0]       dir,
  output logic [BUTTONS*PLAYERS-1:0] btn,
  output logic [PLAYERS-1:0]         start,
  output logic                       coin
);

  localparam int COIN_BIT = JOY_BTN0 + BUTTONS + PLAYERS;

  logic [KEY_N-1:0]           key_q, key_d;
  logic                       tog_q;
  logic [4*PLAYERS-1:0]       dir_q, dir_d;
  logic [BUTTONS*PLAYERS-1:0] btn_q, btn_d;
  logic [PLAYERS-1:0]         start_q, start_d;

  logic [15:0] joy_or;
  logic [16:0] joy_or_x;
  logic [3:0]  key_start;
  logic        coin_src;
  logic        unused_top;

  // Keyboard decode: an event is a change of the toggle bit.
  always_comb begin
    key_d = key_q;
    if (ps2_key[10] != tog_q) begin
      case (ps2_key[8:0])
        SC_P1_UP:    key_d[K_P1_U]   = ps2_key[9];
        SC_P1_DOWN:  key_d[K_P1_D]   = ps2_key[9];
        SC_P1_LEFT:  key_d[K_P1_L]   = ps2_key[9];
        SC_P1_RIGHT: key_d[K_P1_R]   = ps2_key[9];
        SC_P1_B0A:   key_d[K_P1_B0A] = ps2_key[9];
        SC_P1_B0B:   key_d[K_P1_B0B] = ps2_key[9];
        SC_P1_B1:    key_d[K_P1_B1]  = ps2_key[9];
        SC_P2_UP:    key_d[K_P2_U]   = ps2_key[9];
        SC_P2_DOWN:  key_d[K_P2_D]   = ps2_key[9];
        SC_P2_LEFT:  key_d[K_P2_L]   = ps2_key[9];
        SC_P2_RIGHT: key_d[K_P2_R]   = ps2_key[9];
        SC_P2_B0:    key_d[K_P2_B0]  = ps2_key[9];
        SC_START0:   key_d[K_START0] = ps2_key[9];
        SC_START1:   key_d[K_START1] = ps2_key[9];
        SC_COIN:     key_d[K_COIN]   = ps2_key[9];
        default:     ;
      endcase
    end
  end

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_or = joy_or | joystick[16*p +: 16];
    end
  end

  // Start lines come from the keys and from any joystick; start keys for
  // players beyond PLAYERS fall off the slice.
  assign key_start = {2'b00, key_q[K_START1], key_q[K_START0]};
  assign start_d   = key_start[PLAYERS-1:0] | joy_or[JOY_BTN0+BUTTONS +: PLAYERS];

  // The coin bit can sit one past the 16-bit word for the largest
  // configuration; the zero extension makes that joystick coin bit inert.
  assign joy_or_x  = {1'b0, joy_or};
  assign coin_src  = key_q[K_COIN] | joy_or_x[COIN_BIT] | (auto_coin & (|start_q));

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
    logic [15:0] src;
    logic [3:0]  kdir;
    logic [7:0]  kbtn;
    logic [3:0]  rot_dir;
    logic [3:0]  out_dir;
    logic        unused_src;

    assign src = merge ? joy_or : joystick[16*gi +: 16];

    // Only players 1 and 2 have keyboard bindings.
    always_comb begin
      kdir = '0;
      kbtn = '0;
      if (gi == 0) begin
        kdir[JOY_U] = key_q[K_P1_U];
        kdir[JOY_D] = key_q[K_P1_D];
        kdir[JOY_L] = key_q[K_P1_L];
        kdir[JOY_R] = key_q[K_P1_R];
        kbtn[0]     = key_q[K_P1_B0A] | key_q[K_P1_B0B];
        kbtn[1]     = key_q[K_P1_B1];
      end else if (gi == 1) begin
        kdir[JOY_U] = key_q[K_P2_U];
        kdir[JOY_D] = key_q[K_P2_D];
        kdir[JOY_L] = key_q[K_P2_L];
        kdir[JOY_R] = key_q[K_P2_R];
        kbtn[0]     = key_q[K_P2_B0];
      end
    end

    assign rot_dir = rotate_dir(kdir | src[3:0], rot_e'(rotate));

`ifdef INPUT_SOCD_EN
    always_comb begin
      out_dir = rot_dir;
      if (rot_dir[JOY_U] && rot_dir[JOY_D]) begin
        out_dir[JOY_U] = 1'b0;
        out_dir[JOY_D] = 1'b0;
      end
      if (rot_dir[JOY_L] && rot_dir[JOY_R]) begin
        out_dir[JOY_L] = 1'b0;
        out_dir[JOY_R] = 1'b0;
      end
    end
`else
    assign out_dir = rot_dir;
`endif

    assign dir_d[4*gi +: 4]             = out_dir;
    assign btn_d[BUTTONS*gi +: BUTTONS] = kbtn[BUTTONS-1:0] | src[JOY_BTN0 +: BUTTONS];
    assign unused_src                   = ^{src, kbtn};
  end

  assign unused_top = ^{joy_or_x, key_q};

  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      key_q   <= '0;
      tog_q   <= 1'b0;
      dir_q   <= '0;
      btn_q   <= '0;
      start_q <= '0;
    end else begin
      key_q   <= key_d;
      tog_q   <= ps2_key[10];
      dir_q   <= dir_d;
      btn_q   <= btn_d;
      start_q <= start_d;
    end
  end

  assign dir   = dir_q;
  assign btn   = btn_q;
  assign start = start_q;

  arcade_coin_pulser #(
    .COIN_PULSE (COIN_PULSE),
    .CNT_W      (CNT_W)
  ) u_coin (
    .clk_sys  (clk_sys),
    .I_RESETn (I_RESETn),
    .trigger  (coin_src),
    .coin     (coin)
  );

endmodule
